// File: rtl/game_pkg.sv
// Shared definitions for the game input controller.
//   game_state_e      : IDLE/RUN/DEAD encodings, also the value on the state output
//   SPD_*             : encoded step increments chosen by the speed switches
//   DIFF_W            : width of the encoded difficulty
//   encode_speed      : priority encoder, speed switches to step increment
//   encode_difficulty : priority encoder, difficulty switches to level (bit 0 ignored)
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } game_state_e;

  localparam int SPD_W  = 4;
  localparam int DIFF_W = 2;

  localparam logic [SPD_W-1:0] SPD_3 = 4'd3;
  localparam logic [SPD_W-1:0] SPD_4 = 4'd4;
  localparam logic [SPD_W-1:0] SPD_6 = 4'd6;
  localparam logic [SPD_W-1:0] SPD_7 = 4'd7;
  localparam logic [SPD_W-1:0] SPD_9 = 4'd9;

  // Highest set switch wins; no switch selects the slowest speed.
  function automatic logic [SPD_W-1:0] encode_speed(input logic [3:0] sw);
    logic [SPD_W-1:0] enc;
    casez (sw)
      4'b1???: enc = SPD_9;
      4'b01??: enc = SPD_7;
      4'b001?: enc = SPD_6;
      4'b0001: enc = SPD_4;
      default: enc = SPD_3;
    endcase
    return enc;
  endfunction

  // Bit 0 has no level of its own; it falls into the default (easiest) level.
  function automatic logic [DIFF_W-1:0] encode_difficulty(input logic [3:0] sw);
    logic [DIFF_W-1:0] enc;
    casez (sw)
      4'b1???: enc = 2'd3;
      4'b01??: enc = 2'd2;
      4'b001?: enc = 2'd1;
      default: enc = 2'd0;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and rising-edge pulse.
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   btn_raw in  asynchronous raw button
//   level   out debounced button level
//   pulse   out one cycle high in the cycle level first reads 1
// A new level is accepted after DEBOUNCE_CYCLES consecutive synchronized samples
// that differ from the current level. After reset, pulses are withheld until a
// released sample has been seen, so a button held through reset cannot fire.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  // vld*_q track whether the matching sync stage holds a post-reset sample
  logic             vld1_q, vld1_d;
  logic             vld2_q, vld2_d;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    armed_d = armed_q | (vld2_q & ~sync2_q);
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    pulse_d = level_d & ~level_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      armed_q <= armed_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Game input controller: conditions the jump button, runs the game FSM,
// latches the switch encodings and generates the game-step enable.
//   CLK100MHZ     in  system clock
//   reset_btn     in  synchronous active-high reset
//   jump_btn      in  raw jump/start button
//   speed_in      in  speed switches
//   difficulty_in in  difficulty switches
//   isdead        in  death flag from physics
//   jump          out debounced button level
//   jump_pulse    out one-cycle pulse per debounced press
//   start         out game active (RUN or DEAD)
//   tick          out one-cycle game-step enable
//   speed         out encoded speed (frozen outside IDLE)
//   difficulty    out encoded difficulty (frozen outside IDLE)
//   state         out FSM state
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | no game; switches tracked, accumulator held at 0
// ST_RUN  | game in progress; accumulator advances, ticks issued
// ST_DEAD | game over screen; accumulator frozen, waits for a press
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACC_W           = 33,
  parameter int TICK_BIT        = 25
) (
  input  logic              CLK100MHZ,
  input  logic              reset_btn,
  input  logic              jump_btn,
  input  logic [3:0]        speed_in,
  input  logic [3:0]        difficulty_in,
  input  logic              isdead,
  output logic              jump,
  output logic              jump_pulse,
  output logic              start,
  output logic              tick,
  output logic [SPD_W-1:0]  speed,
  output logic [DIFF_W-1:0] difficulty,
  output logic [1:0]        state
);

  game_state_e       state_q, state_d;
  logic [SPD_W-1:0]  speed_q, speed_d;
  logic [DIFF_W-1:0] diff_q, diff_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              tick_q, tick_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_jump_db (
    .clk    (CLK100MHZ),
    .rst    (reset_btn),
    .btn_raw(jump_btn),
    .level  (jump),
    .pulse  (jump_pulse)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (jump_pulse) state_d = ST_RUN;
      ST_RUN:  if (isdead)     state_d = ST_DEAD;
      ST_DEAD: if (jump_pulse) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    diff_d  = diff_q;
    if (state_q == ST_IDLE) begin
      speed_d = encode_speed(speed_in);
      diff_d  = encode_difficulty(difficulty_in);
    end

    case (state_q)
      ST_RUN:  acc_d = acc_q + ACC_W'(speed_q);
      ST_DEAD: acc_d = acc_q;
      default: acc_d = '0;
    endcase

    // Gated by the next state so the edge that leaves RUN cannot emit a tick.
    tick_d = (state_d == ST_RUN) & acc_d[TICK_BIT] & ~acc_q[TICK_BIT];
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_btn) begin
      state_q <= ST_IDLE;
      speed_q <= SPD_3;
      diff_q  <= '0;
      acc_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      diff_q  <= diff_d;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
    end
  end

  assign start      = (state_q != ST_IDLE);
  assign tick       = tick_q;
  assign speed      = speed_q;
  assign difficulty = diff_q;
  assign state      = state_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Input-side controller for the game. It drives the engines; the display/audio path is the consumer end.
- Conditions the raw jump button (2-flop sync, debounce, edge pulse) and runs the IDLE/RUN/DEAD game state machine.
- Produces a one-cycle game-step enable `tick` from a speed-scaled accumulator. This replaces the ripple-derived divided clock, so physics, map and score engines run on CLK100MHZ with `tick` as their enable.
- Registers the speed and difficulty switch encodings and freezes them while a game is in progress.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a new button level (10 ms at 100 MHz).
- ACC_W, 33: step accumulator width.
- TICK_BIT, 25: accumulator bit whose 0->1 transition generates `tick`.

Ports:
- CLK100MHZ  in  1  system clock.
- reset_btn  in  1  reset; synchronous, active-high.
- jump_btn  in  1  raw asynchronous jump/start button.
- speed_in  in  4  speed switches.
- difficulty_in  in  4  difficulty switches.
- isdead  in  1  death flag from the physics engine.
- jump  out  1  debounced button level.
- jump_pulse  out  1  one-cycle pulse on each debounced rising edge.
- start  out  1  game active (high in RUN and DEAD).
- tick  out  1  one-cycle game-step enable.
- speed  out  4  encoded speed.
- difficulty  out  2  encoded difficulty.
- state  out  2  FSM state: IDLE=0, RUN=1, DEAD=2.

Behaviour:
- Reset (synchronous, highest priority, from any state):
  - state=IDLE; jump=0, jump_pulse=0, start=0, tick=0.
  - speed=3, difficulty=0; accumulator=0; debounce counter=0; sync flops=0.
- Synchronizer: jump_btn passes through 2 flops.
- Debounce:
  - A counter increments while the synchronized sample differs from `jump`, and clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, `jump` takes the sample on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no change.
  - Latency from a clean press to `jump`=1 is 2 + DEBOUNCE_CYCLES cycles.
- jump_pulse: asserted in the same cycle `jump` first reads 1; exactly one cycle per press; never asserted on release. `jump` and `jump_pulse` are active in every state.
- Encoders (registered, one cycle latency), updated only in IDLE, held in RUN and DEAD:
  - speed priority: speed_in[3]->9, [2]->7, [1]->6, [0]->4, none->3.
  - difficulty priority: difficulty_in[3]->3, [2]->2, [1]->1, otherwise 0 (bit 0 ignored).
- Accumulator:
  - In RUN: acc <= acc + speed (zero-extended), modulo 2^ACC_W, free wrap.
  - In IDLE: held at 0. In DEAD: frozen.
  - tick=1 for one cycle when acc[TICK_BIT] was 0 in the previous cycle and is 1 now.
  - Since speed<=9, at most one tick per cycle. Tick period is 2^(TICK_BIT+1)/speed cycles ±1.
  - tick is never asserted outside RUN.
- FSM transitions:
  - IDLE -> RUN on jump_pulse. start rises in the same cycle state reads RUN; the accumulator starts from 0.
  - RUN -> DEAD when isdead=1 is sampled. If isdead and jump_pulse coincide, go to DEAD; the pulse is still output.
  - DEAD -> IDLE on jump_pulse. A second press is then needed to start a new game; a single press never goes DEAD->RUN.
  - isdead is ignored in IDLE and DEAD.
- Reset mid-game: returns to IDLE next cycle. Any tick already computed for that cycle is suppressed, and a held button does not re-trigger until it is released and pressed again.

Decomposition:
- Package game_pkg holds:
  - state encodings (ST_IDLE, ST_RUN, ST_DEAD);
  - speed table constants (SPD_3..SPD_9);
  - difficulty width constant DIFF_W=2.
- One sub-module: btn_debounce (synchronizer + debounce counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES, instantiated once.
- The FSM, encoders and accumulator stay in game_ctrl.

Test Plan (sim with DEBOUNCE_CYCLES=4, TICK_BIT=5, ACC_W=8):
- Reset: assert reset_btn for 2 cycles, then release -> state=0, start=0, tick=0, speed=3, difficulty=0; next cycle speed/difficulty reflect the switches.
- Bounce: jump_btn high for 3 cycles, low for 2, then high for 10 -> exactly one jump_pulse, 6 cycles after the final rise (2 sync + 4 debounce); no pulse from the 3-cycle glitch.
- Start and tick: speed_in=4'b0100 (speed=7), press -> state=RUN, start=1. Then:
  - first tick when acc crosses 32, i.e. 5 increments after entering RUN;
  - subsequent ticks every 64/7, i.e. 9 or 10 cycles;
  - changing speed_in during RUN leaves speed at 7.
- Death: isdead=1 for 1 cycle in RUN -> state=DEAD next cycle, start=1, no further ticks, acc frozen. One press -> IDLE and start=0. A second press -> RUN with acc restarting at 0.
- Simultaneous events: jump_pulse and isdead in the same RUN cycle -> DEAD, pulse visible. reset_btn together with a jump_pulse in IDLE -> stays IDLE. Holding jump_btn through reset release -> no jump_pulse until the button is released and pressed again.
- Encoders: all speed_in bits set -> 9; difficulty_in=4'b0001 -> 0; difficulty_in=4'b0110 -> 2.
